// File: rtl/data_mem_ctrl_pkg.sv
// Shared types, transfer-size constants and small helpers for the data memory controller.
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [3:0] SZ_B = 4'd1;
  localparam logic [3:0] SZ_H = 4'd2;
  localparam logic [3:0] SZ_W = 4'd4;
  localparam logic [3:0] SZ_D = 4'd8;

  localparam int DEFAULT_TIMEOUT = 16;

  function automatic logic size_legal(input logic [3:0] sz);
    return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) || (sz == SZ_D);
  endfunction

  // Only meaningful for legal sizes: sz-1 over three bits is the alignment mask (8 wraps to 7).
  function automatic logic addr_aligned(input logic [63:0] a, input logic [3:0] sz);
    logic [2:0] mask;
    mask = sz[2:0] - 3'd1;
    return (a[2:0] & mask) == 3'b000;
  endfunction

  function automatic logic [63:0] zext_bytes(input logic [63:0] d, input logic [3:0] sz);
    logic [63:0] r;
    case (sz)
      SZ_B:    r = {56'd0, d[7:0]};
      SZ_H:    r = {48'd0, d[15:0]};
      SZ_W:    r = {32'd0, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts BUSY cycles; tc flags the last cycle allowed before the wait is declared timed out.
module mem_timeout_counter #(
  parameter int TIMEOUT = 16,
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store front end: validates a decoded request, holds it to memory until completion or timeout.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [3:0]  xfer_size,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [3:0]  mem_size,
  output logic [63:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output state_t      state_dbg
);

  // Handshake: a request is a level on mem_read/mem_write while the instruction is held; the
  // controller owns it from acceptance, and memory completes it with a one-cycle mem_ready in BUSY.

  state_t state, state_next;
  logic   req, legal, busy, tc, cnt_clear;

  assign req   = mem_read | mem_write;
  assign legal = (mem_read ^ mem_write) && size_legal(xfer_size) && addr_aligned(addr, xfer_size);
  assign busy  = (state == ST_BUSY);

  assign cnt_clear = busy && (mem_ready || tc);

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (busy),
    .tc     (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      ST_IDLE: begin
        // stall rises in the accepting cycle so the PC never advances past the load/store
        stall = legal && !reset;
        if (req) begin
          state_next = legal ? ST_BUSY : ST_ERR;
        end
      end
      ST_BUSY: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ready) begin
          state_next = ST_DONE;
        end else if (tc) begin
          state_next = ST_ERR;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        err        = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      rdata     <= '0;
    end else begin
      if (state == ST_IDLE && legal) begin
        mem_we    <= mem_write;
        mem_addr  <= addr;
        mem_wdata <= wdata;
        mem_size  <= xfer_size;
      end
      // rdata only moves on a completed read; stores and errors leave the last load visible
      if (busy && mem_ready && !mem_we) begin
        rdata <= zext_bytes(mem_rdata, mem_size);
      end
    end
  end

  assign state_dbg = state;

endmodule
